// File: rtl/tia_audio_mixer.sv
// tia_audio_mixer: volume-weight the TIA AUD0/AUD1 tone bits, box-car decimate
// over DECIM audio ticks and emit 16-bit PCM through a 2-entry valid/ready FIFO.
//
// Optional feature: define TIA_MIX_DCBLOCK_EN to add a one-pole DC-blocking
// stage (FILT state). PCM then becomes signed and gains one cycle of latency.
//
// Ports:
//   clk_i         system clock, all registers update on posedge
//   rst_ni        synchronous active-low reset
//   sample_en_i   one-clock strobe per audio tick
//   aud0_i/aud1_i channel tone bits
//   audv0_i/audv1_i 4-bit channel volumes
//   pcm_o         FIFO head sample (0 when empty)
//   pcm_valid_o   FIFO non-empty
//   pcm_ready_i   consumer pops head when pcm_valid_o & pcm_ready_i
//   overflow_o    sticky flag: a completed sample was dropped on a full FIFO
module tia_audio_mixer #(
    parameter int DECIM = 4,
    parameter int SHIFT = 9,
    parameter int DC_K  = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sample_en_i,
    input  logic        aud0_i,
    input  logic        aud1_i,
    input  logic [3:0]  audv0_i,
    input  logic [3:0]  audv1_i,
    output logic [15:0] pcm_o,
    output logic        pcm_valid_o,
    input  logic        pcm_ready_i,
    output logic        overflow_o
);
    localparam int CW = $clog2(DECIM);
    localparam int AW = 5 + CW;

`ifdef TIA_MIX_DCBLOCK_EN
    typedef enum logic [1:0] {IDLE, EMIT, FILT} state_e;
`else
    typedef enum logic {IDLE, EMIT} state_e;
`endif

    state_e          state_q, state_d;
    logic [4:0]      level;
    logic [AW-1:0]   acc_q, hold_q, sum;
    logic [CW-1:0]   cnt_q;
    logic            close;
    logic [31:0]     wide;
    logic [15:0]     pcm_raw, push_data;
    logic            push, pop, accept, full;
    logic [15:0]     mem_q [2];
    logic            wp_q, rp_q;
    logic [1:0]      fcnt_q;

    assign level   = (aud0_i ? {1'b0, audv0_i} : 5'd0) + (aud1_i ? {1'b0, audv1_i} : 5'd0);
    assign sum     = acc_q + AW'(level);
    assign close   = sample_en_i && (cnt_q == CW'(DECIM - 1));
    assign wide    = 32'(hold_q) << SHIFT;
    assign pcm_raw = (|wide[31:16]) ? 16'hFFFF : wide[15:0];

`ifdef TIA_MIX_DCBLOCK_EN
    // avg_q is fixed point: 16 integer bits, 8 fraction bits.
    logic [14:0]        raw_q;
    logic signed [23:0] avg_q;
    logic signed [24:0] diff;
    logic [15:0]        y;
    assign diff = $signed({2'b00, raw_q, 8'h00}) - $signed({avg_q[23], avg_q});
    // Saturate the integer part of the difference to a signed 16-bit sample.
    assign y    = (diff[24] != diff[23]) ? (diff[24] ? 16'h8000 : 16'h7FFF) : diff[23:8];
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            raw_q <= '0;
            avg_q <= '0;
        end else begin
            if (state_q == EMIT) raw_q <= pcm_raw[15:1];
            if (state_q == FILT) avg_q <= avg_q + 24'(diff >>> DC_K);
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_data = pcm_raw;
        case (state_q)
            IDLE: state_d = close ? EMIT : IDLE;
`ifdef TIA_MIX_DCBLOCK_EN
            EMIT: state_d = FILT;
            FILT: begin
                push      = 1'b1;
                push_data = y;
                state_d   = IDLE;
            end
`else
            EMIT: begin
                push    = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign full        = fcnt_q == 2'd2;
    assign pop         = (fcnt_q != 2'd0) && pcm_ready_i;
    assign accept      = push && (!full || pop);
    assign pcm_valid_o = fcnt_q != 2'd0;
    assign pcm_o       = pcm_valid_o ? mem_q[rp_q] : 16'h0000;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            fcnt_q     <= 2'd0;
            overflow_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (sample_en_i) begin
                acc_q <= close ? '0 : sum;
                cnt_q <= close ? '0 : cnt_q + 1'b1;
            end
            if (close) hold_q <= sum;
            if (accept) begin
                mem_q[wp_q] <= push_data;
                wp_q        <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
            fcnt_q <= fcnt_q + 2'(accept) - 2'(pop);
            if (push && !accept) overflow_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tia_audio_mixer.sv
// tb_tia_audio_mixer: directed-vector bench for tia_audio_mixer.
module tb_tia_audio_mixer;
`ifdef TIA_MIX_DCBLOCK_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic        aud0 = 1'b0, aud1 = 1'b0;
    logic [3:0]  audv0 = 4'd0, audv1 = 4'd0;
    logic [15:0] pcm;
    logic        pcm_valid, overflow;
    logic        pcm_ready = 1'b1;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    tia_audio_mixer dut (
        .clk_i(clk), .rst_ni(rst_n), .sample_en_i(sample_en),
        .aud0_i(aud0), .aud1_i(aud1), .audv0_i(audv0), .audv1_i(audv1),
        .pcm_o(pcm), .pcm_valid_o(pcm_valid), .pcm_ready_i(pcm_ready),
        .overflow_o(overflow)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe spaced at least 4 clocks from the previous one; returns at the
    // negedge one cycle after the strobe was sampled.
    task automatic strobe();
        repeat (3) @(negedge clk);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    task automatic set_lv(input logic a0, input logic [3:0] v0, input logic a1, input logic [3:0] v1);
        aud0 = a0; audv0 = v0; aud1 = a1; audv1 = v1;
    endtask

    // Four strobes at the current level; optionally check the closing latency
    // and the emitted value (with pcm_ready held high).
    task automatic window(input bit lat, input logic [15:0] exp);
        repeat (4) strobe();
        if (lat) begin
            for (int i = 1; i < LAT; i++) begin
                chk("lat_lo", {15'd0, pcm_valid}, 16'd0);
                @(negedge clk);
            end
            chk("lat_hi", {15'd0, pcm_valid}, 16'd1);
            chk("pcm", pcm, exp);
            @(negedge clk);
            chk("one_clk", {15'd0, pcm_valid}, 16'd0);
        end
    endtask

    initial begin
        logic [15:0] prev;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample_en = 1'($urandom);
            set_lv(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
            pcm_ready = 1'($urandom);
        end
        chk("rst_pcm", pcm, 16'h0000);
        chk("rst_valid", {15'd0, pcm_valid}, 16'd0);
        chk("rst_ovf", {15'd0, overflow}, 16'd0);
        sample_en = 1'b0;
        pcm_ready = 1'b1;
        rst_n = 1'b1;
`ifdef TIA_MIX_DCBLOCK_EN
        set_lv(1, 15, 0, 0);
        window(1, 16'h3C00);
        window(1, 16'h3BC4);
        window(1, 16'h3B88);
        prev = 16'h3B88;
        for (int i = 0; i < 4; i++) begin
            repeat (4) strobe();
            repeat (LAT - 1) @(negedge clk);
            chk("dc_valid", {15'd0, pcm_valid}, 16'd1);
            chk("dc_sign", {15'd0, pcm[15]}, 16'd0);
            chk("dc_decay", {15'd0, pcm < prev}, 16'd1);
            prev = pcm;
        end
`else
        set_lv(1, 15, 0, 0);
        window(1, 16'h7800);
        set_lv(1, 15, 1, 15);
        window(1, 16'hF000);
        set_lv(1, 3, 0, 0);
        window(1, 16'h1800);
        pcm_ready = 1'b0;
        set_lv(1, 1, 0, 0);
        window(0, 16'h0000);
        set_lv(1, 2, 0, 0);
        window(0, 16'h0000);
        repeat (3) @(negedge clk);
        chk("ovf_pre", {15'd0, overflow}, 16'd0);
        set_lv(1, 3, 0, 0);
        window(0, 16'h0000);
        repeat (3) @(negedge clk);
        chk("ovf_set", {15'd0, overflow}, 16'd1);
        chk("hold_valid", {15'd0, pcm_valid}, 16'd1);
        chk("head0", pcm, 16'h0800);
        pcm_ready = 1'b1;
        @(negedge clk);
        chk("head1", pcm, 16'h1000);
        @(negedge clk);
        chk("drained", {15'd0, pcm_valid}, 16'd0);
        chk("ovf_sticky", {15'd0, overflow}, 16'd1);
        set_lv(1, 15, 1, 15);
        strobe();
        strobe();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_ovf", {15'd0, overflow}, 16'd0);
        chk("mid_rst_valid", {15'd0, pcm_valid}, 16'd0);
        set_lv(1, 1, 0, 0);
        window(1, 16'h0800);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
